// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-level arbiter sharing one UART tx byte transmitter between NUM_REQ sources
// Optional idle-grant watchdog is built in when UART_ARB_WDOG_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int PRIORITY_MODE = 0,
    parameter int WDOG_CYCLES   = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_start,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_busy,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     err_drop,
    output logic                   wdog_fired,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANTED, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] err_drop_q, err_drop_d;
    logic [IW-1:0]      last_q, last_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;

    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [IW-1:0]      win_idx;
    int                 rr_j;
    logic               fwd;
    logic               req_g;
    logic               wdog_hit;

    // last_q doubles as the index of the current owner while GRANTED/DRAIN
    assign req_g    = req[last_q];
    assign eligible = req & ~mask;

    always_comb begin
        req_busy = {NUM_REQ{1'b1}};
        if (state_q == GRANTED) begin
            req_busy = ~grant_q | {NUM_REQ{tx_busy | tx_start_q}};
        end
    end

    assign fwd = |(req_start & ~req_busy);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_j      = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_j = (PRIORITY_MODE == 1) ? (k - 1) : ((int'(last_q) + k) % NUM_REQ);
            if (eligible[rr_j]) begin
                win_found = 1'b1;
                win_idx   = IW'(rr_j);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        err_drop_d = err_drop_q | (req_start & req_busy);
        if (fwd) begin
            tx_start_d = 1'b1;
            tx_data_d  = req_data[8*last_q +: 8];
        end
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = GRANTED;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    last_d           = win_idx;
                end
            end
            GRANTED: begin
                if (!req_g || wdog_hit) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!tx_start_q && !tx_busy) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            err_drop_q <= '0;
            last_q     <= IW'(NUM_REQ - 1);
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            err_drop_q <= err_drop_d;
            last_q     <= last_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef UART_ARB_WDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES);

    logic [CW-1:0]      wdog_cnt_q, wdog_cnt_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic               wdog_fired_q, wdog_fired_d;

    // Counts only genuinely idle owned cycles; tx activity or a forwarded byte restarts it
    always_comb begin
        wdog_cnt_d = '0;
        wdog_hit   = 1'b0;
        if (state_q == GRANTED && req_g && !fwd && !tx_busy) begin
            if (wdog_cnt_q == CW'(WDOG_CYCLES - 1)) begin
                wdog_hit = 1'b1;
            end else begin
                wdog_cnt_d = wdog_cnt_q + 1'b1;
            end
        end
        mask_d = mask_q & req;
        if (wdog_hit) begin
            mask_d[last_q] = 1'b1;
        end
        wdog_fired_d = wdog_fired_q | wdog_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q   <= '0;
            mask_q       <= '0;
            wdog_fired_q <= 1'b0;
        end else begin
            wdog_cnt_q   <= wdog_cnt_d;
            mask_q       <= mask_d;
            wdog_fired_q <= wdog_fired_d;
        end
    end

    assign mask       = mask_q;
    assign wdog_fired = wdog_fired_q;
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES < 2);
    assign wdog_hit    = 1'b0;
    assign mask        = '0;
    assign wdog_fired  = 1'b0;
`endif

    assign grant    = grant_q;
    assign err_drop = err_drop_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter (round-robin and fixed-priority instances)
module tb_uart_tx_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   req, req_start, req_busy, grant, err_drop;
    logic [8*N-1:0] req_data;
    logic           wdog_fired, tx_start, tx_busy;
    logic [7:0]     tx_data;

    logic [N-1:0]   req_f, req_start_f, req_busy_f, grant_f, err_drop_f;
    logic [8*N-1:0] req_data_f;
    logic           wdog_fired_f, tx_start_f, tx_busy_f;
    logic [7:0]     tx_data_f;

    uart_tx_arbiter #(.NUM_REQ(N), .PRIORITY_MODE(0), .WDOG_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_start(req_start), .req_data(req_data),
        .req_busy(req_busy), .grant(grant), .err_drop(err_drop), .wdog_fired(wdog_fired),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .PRIORITY_MODE(1), .WDOG_CYCLES(65535)) dut_f (
        .clk(clk), .rst_n(rst_n), .req(req_f), .req_start(req_start_f), .req_data(req_data_f),
        .req_busy(req_busy_f), .grant(grant_f), .err_drop(err_drop_f), .wdog_fired(wdog_fired_f),
        .tx_start(tx_start_f), .tx_data(tx_data_f), .tx_busy(tx_busy_f)
    );

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         cyc;
    } sb_t;

    sb_t sb[$];
    sb_t sb_f[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  bcnt  = 0;
    int  bcnt_f = 0;

    always @(posedge clk) cyc++;

    // UART transmitter model: busy for 10 cycles after each start pulse
    always @(posedge clk) begin
        #1;
        if (tx_start) bcnt = 10;
        else if (bcnt > 0) bcnt--;
        tx_busy = (bcnt != 0);
        if (tx_start_f) bcnt_f = 10;
        else if (bcnt_f > 0) bcnt_f--;
        tx_busy_f = (bcnt_f != 0);
    end

    always @(negedge clk) begin : mon_rr
        sb_t e;
        logic [N-1:0] eg;
        if (tx_start === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rr_unexpected_start: tx_data=%02h grant=%b, no byte expected", tx_data, grant);
            end else begin
                e = sb.pop_front();
                eg = '0;
                eg[e.idx] = 1'b1;
                if (tx_data !== e.data || grant !== eg || cyc != e.cyc + 1) begin
                    bad++;
                    $display("FAIL rr_byte: got data=%02h grant=%b cyc=%0d, want data=%02h grant=%b cyc=%0d",
                             tx_data, grant, cyc, e.data, eg, e.cyc + 1);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_fp
        sb_t e;
        logic [N-1:0] eg;
        if (tx_start_f === 1'b1) begin
            total++;
            if (sb_f.size() == 0) begin
                bad++;
                $display("FAIL fp_unexpected_start: tx_data=%02h grant=%b, no byte expected", tx_data_f, grant_f);
            end else begin
                e = sb_f.pop_front();
                eg = '0;
                eg[e.idx] = 1'b1;
                if (tx_data_f !== e.data || grant_f !== eg || cyc != e.cyc + 1) begin
                    bad++;
                    $display("FAIL fp_byte: got data=%02h grant=%b cyc=%0d, want data=%02h grant=%b cyc=%0d",
                             tx_data_f, grant_f, cyc, e.data, eg, e.cyc + 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input bit f, input int i, input logic [7:0] d);
        int n = 0;
        while ((f ? req_busy_f[i] : req_busy[i]) !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout_%0d: req_busy stuck at 1, want 0", i);
        end else if (f) begin
            req_data_f[8*i +: 8] = d;
            req_start_f[i] = 1'b1;
            sb_f.push_back('{idx: i, data: d, cyc: cyc});
            step();
            req_start_f[i] = 1'b0;
        end else begin
            req_data[8*i +: 8] = d;
            req_start[i] = 1'b1;
            sb.push_back('{idx: i, data: d, cyc: cyc});
            step();
            req_start[i] = 1'b0;
        end
    endtask

    task automatic wait_grant(input bit f, input bit want_zero, output logic [N-1:0] g);
        int n = 0;
        g = f ? grant_f : grant;
        while (((g == '0) != want_zero) && n < 300) begin
            step();
            n++;
            g = f ? grant_f : grant;
        end
        if ((g == '0) != want_zero) begin
            total++;
            bad++;
            $display("FAIL wait_grant_timeout: grant=%b, want %s", g, want_zero ? "zero" : "nonzero");
        end
    endtask

    task automatic wait_sb();
        int n = 0;
        while ((sb.size() != 0 || sb_f.size() != 0) && n < 300) begin
            step();
            n++;
        end
        total++;
        if (sb.size() != 0 || sb_f.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: pending rr=%0d fp=%0d, want 0 0", sb.size(), sb_f.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; req_start = '0;
        req_f = '0; req_start_f = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        total++; if (grant !== 3'b000)     begin bad++; $display("FAIL reset_grant: got %b want 000", grant); end
        total++; if (tx_start !== 1'b0)    begin bad++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        total++; if (tx_data !== 8'h00)    begin bad++; $display("FAIL reset_tx_data: got %02h want 00", tx_data); end
        total++; if (err_drop !== 3'b000)  begin bad++; $display("FAIL reset_err_drop: got %b want 000", err_drop); end
        total++; if (wdog_fired !== 1'b0)  begin bad++; $display("FAIL reset_wdog: got %b want 0", wdog_fired); end
        total++; if (req_busy !== 3'b111)  begin bad++; $display("FAIL reset_req_busy: got %b want 111", req_busy); end
        total++; if (grant_f !== 3'b000)   begin bad++; $display("FAIL reset_grant_fp: got %b want 000", grant_f); end
    endtask

    task automatic test_single();
        logic [N-1:0] g;
        logic [7:0] msg [3];
        msg[0] = 8'h4C; msg[1] = 8'h4F; msg[2] = 8'h47;
        do_reset();
        req[1] = 1'b1;
        step();
        total++; if (grant !== 3'b010) begin bad++; $display("FAIL single_grant_latency: got %b want 010", grant); end
        for (int b = 0; b < 3; b++) begin
            send_byte(1'b0, 1, msg[b]);
            total++; if (grant !== 3'b010) begin bad++; $display("FAIL single_grant_hold: got %b want 010", grant); end
        end
        req[1] = 1'b0;
        wait_grant(1'b0, 1'b1, g);
        wait_sb();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g;
        int order [4];
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
        do_reset();
        req = 3'b111;
        for (int m = 0; m < 4; m++) begin
            wait_grant(1'b0, 1'b0, g);
            total++;
            if (g !== (3'b001 << order[m])) begin
                bad++;
                $display("FAIL rr_order_%0d: got %b want %b", m, g, 3'b001 << order[m]);
            end
            for (int b = 0; b < 2; b++) send_byte(1'b0, order[m], 8'((m << 4) | b));
            req[order[m]] = 1'b0;
            wait_grant(1'b0, 1'b1, g);
            if (m < 3) begin
                req[order[m]] = 1'b1;
                step();
                total++; if (grant === 3'b000) begin bad++; $display("FAIL rr_regrant_1cycle: got %b want nonzero", grant); end
            end
        end
        req = '0;
        wait_grant(1'b0, 1'b1, g);
        wait_sb();
    endtask

    task automatic test_fixed();
        logic [N-1:0] g;
        do_reset();
        req_f = 3'b110;
        step();
        total++; if (grant_f !== 3'b010) begin bad++; $display("FAIL fp_first: got %b want 010", grant_f); end
        send_byte(1'b1, 1, 8'hA1);
        req_f[0] = 1'b1;
        send_byte(1'b1, 1, 8'hA2);
        total++; if (grant_f !== 3'b010) begin bad++; $display("FAIL fp_no_preempt: got %b want 010", grant_f); end
        req_f[1] = 1'b0;
        wait_grant(1'b1, 1'b1, g);
        wait_grant(1'b1, 1'b0, g);
        total++; if (g !== 3'b001) begin bad++; $display("FAIL fp_second: got %b want 001", g); end
        send_byte(1'b1, 0, 8'hB0);
        req_f[0] = 1'b0;
        wait_grant(1'b1, 1'b1, g);
        wait_grant(1'b1, 1'b0, g);
        total++; if (g !== 3'b100) begin bad++; $display("FAIL fp_third: got %b want 100", g); end
        req_f = '0;
        wait_grant(1'b1, 1'b1, g);
        wait_sb();
    endtask

    task automatic test_illegal();
        logic [N-1:0] g;
        do_reset();
        req = 3'b001;
        wait_grant(1'b0, 1'b0, g);
        total++; if (g !== 3'b001) begin bad++; $display("FAIL ill_grant: got %b want 001", g); end
        total++; if (req_busy !== 3'b110) begin bad++; $display("FAIL ill_req_busy: got %b want 110", req_busy); end
        req_data[23:16] = 8'hEE;
        req_start[2] = 1'b1;
        step();
        req_start[2] = 1'b0;
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL ill_no_start: got %b want 0", tx_start); end
        total++; if (err_drop !== 3'b100) begin bad++; $display("FAIL ill_drop_other: got %b want 100", err_drop); end
        send_byte(1'b0, 0, 8'h55);
        req_data[7:0] = 8'h66;
        req_start[0] = 1'b1;
        step();
        req_start[0] = 1'b0;
        total++; if (err_drop !== 3'b101) begin bad++; $display("FAIL ill_drop_busy: got %b want 101", err_drop); end
        wait_sb();
        total++; if (err_drop !== 3'b101) begin bad++; $display("FAIL ill_sticky: got %b want 101", err_drop); end
        req = '0;
        wait_grant(1'b0, 1'b1, g);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g;
        do_reset();
        req = 3'b001;
        wait_grant(1'b0, 1'b0, g);
        send_byte(1'b0, 0, 8'h01);
        send_byte(1'b0, 0, 8'h02);
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL rstmid_pre_start: got %b want 1", tx_start); end
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rstmid_tx_start: got %b want 0", tx_start); end
        total++; if (grant !== 3'b000)  begin bad++; $display("FAIL rstmid_grant: got %b want 000", grant); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rstmid_tx_data: got %02h want 00", tx_data); end
        total++; if (req_busy !== 3'b111) begin bad++; $display("FAIL rstmid_req_busy: got %b want 111", req_busy); end
        step();
        step();
        rst_n = 1'b1;
        step();
        total++; if (grant !== 3'b001) begin bad++; $display("FAIL rstmid_regrant: got %b want 001", grant); end
        send_byte(1'b0, 0, 8'h03);
        send_byte(1'b0, 0, 8'h04);
        req = '0;
        wait_grant(1'b0, 1'b1, g);
        wait_sb();
    endtask

`ifdef UART_ARB_WDOG_EN
    task automatic test_watchdog();
        logic [N-1:0] g;
        do_reset();
        req = 3'b011;
        step();
        total++; if (grant !== 3'b001) begin bad++; $display("FAIL wd_grant: got %b want 001", grant); end
        for (int k = 0; k < 15; k++) step();
        total++; if (wdog_fired !== 1'b0) begin bad++; $display("FAIL wd_early: got %b want 0", wdog_fired); end
        step();
        total++; if (wdog_fired !== 1'b1) begin bad++; $display("FAIL wd_fire: got %b want 1", wdog_fired); end
        wait_grant(1'b0, 1'b1, g);
        wait_grant(1'b0, 1'b0, g);
        total++; if (g !== 3'b010) begin bad++; $display("FAIL wd_next: got %b want 010", g); end
        req_start[0] = 1'b1;
        step();
        req_start[0] = 1'b0;
        total++; if (err_drop !== 3'b001) begin bad++; $display("FAIL wd_revoked_drop: got %b want 001", err_drop); end
        req[1] = 1'b0;
        wait_grant(1'b0, 1'b1, g);
        step(); step(); step();
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL wd_masked: got %b want 000", grant); end
        req[0] = 1'b0;
        step();
        req[0] = 1'b1;
        step();
        total++; if (grant !== 3'b001) begin bad++; $display("FAIL wd_unmask: got %b want 001", grant); end
        req = '0;
        wait_grant(1'b0, 1'b1, g);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req = '0; req_start = '0; req_data = '0;
        req_f = '0; req_start_f = '0; req_data_f = '0;
        tx_busy = 1'b0; tx_busy_f = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_fixed();
        test_illegal();
        test_reset_mid();
`ifdef UART_ARB_WDOG_EN
        test_watchdog();
`endif
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
